// File: rtl/uart_receiver.sv
// uart_receiver
// Deserializes an 8N1, LSB-first asynchronous serial line into bytes and
// presents them through a single-entry holding register.
//
// Ports
//   clk            system clock, all state changes on the rising edge
//   rst            synchronous active-high reset; abandons any partial frame
//   uart_rx        asynchronous serial input, idle high
//   rx_data[7:0]   received byte, stable while rx_valid is high
//   rx_valid       holding register contains a byte
//   rx_ready       consumer accepts the byte
//   framing_error  one-cycle pulse: stop bit sampled low, byte discarded
//   overrun        one-cycle pulse: good byte dropped, holding register busy
//   fsm_state[2:0] current receive state (IDLE=0 START=1 DATA=2 STOP=3 WAIT_HIGH=4)
//
// Handshake: a byte transfers on every rising edge where rx_valid && rx_ready.
// Once rx_valid is high, rx_data does not change until that transfer happens.
// The producer side (this block) never waits on rx_ready; it drops new bytes
// instead, and it reports each dropped byte on overrun.

module uart_receiver #(
  parameter int unsigned CLK_HZ     = 12_000_000,
  parameter int unsigned BAUDRATE   = 115200,
  parameter int unsigned SYNC_DEPTH = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       framing_error,
  output logic       overrun,
  output logic [2:0] fsm_state
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUDRATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t                state, state_next;
  logic [SYNC_DEPTH-1:0] sync;
  logic                  rx_s;
  logic [CNT_W-1:0]      bit_cnt;
  logic [2:0]            bit_idx;
  logic [7:0]            shift;

  // Per-cycle strobes decoded by the FSM.
  logic cnt_clr;
  logic shift_en;
  logic stop_good;
  logic stop_bad;
  logic hold_free;

  assign rx_s      = sync[SYNC_DEPTH-1];
  assign fsm_state = state;

  // The holding register may be reloaded in the same cycle it is drained.
  assign hold_free = !rx_valid || rx_ready;

  wire last_half = (bit_cnt == CNT_W'(HALF_BIT - 1));
  wire last_bit  = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    shift_en   = 1'b0;
    stop_good  = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s) state_next = START;
      end
      START: begin
        if (last_half) begin
          cnt_clr = 1'b1;
          // A line that is high again at mid-start-bit was only a glitch.
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (last_bit) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (last_bit) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            stop_good  = 1'b1;
            // Returning to IDLE at mid-stop-bit leaves half a bit of margin
            // to catch the next start edge of a back-to-back frame.
            state_next = IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // A held-low break must not be decoded as a stream of 0x00 frames.
        cnt_clr = 1'b1;
        if (rx_s) state_next = IDLE;
      end
      default: begin
        cnt_clr    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sync          <= '1;
      bit_cnt       <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state   <= state_next;
      sync    <= {sync[SYNC_DEPTH-2:0], uart_rx};
      bit_cnt <= cnt_clr ? '0 : bit_cnt + 1'b1;

      if (state == IDLE) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        // Shifting right places the first (LSB) bit in bit 0 after 8 shifts.
        shift   <= {rx_s, shift[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end

      framing_error <= stop_bad;
      overrun       <= stop_good && !hold_free;

      if (stop_good && hold_free) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
// Directed bench for uart_receiver at default parameters (104 clocks/bit).
// The driver pushes each byte that should be delivered into exp_q; the
// monitor pops and compares on every rx_valid && rx_ready handshake and
// counts framing_error / overrun pulses.

module tb_uart_receiver;

  localparam int BIT_CLKS = 104;

  logic       clk;
  logic       rst;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       framing_error;
  logic       overrun;
  logic [2:0] fsm_state;

  uart_receiver dut (
    .clk           (clk),
    .rst           (rst),
    .uart_rx       (uart_rx),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .framing_error (framing_error),
    .overrun       (overrun),
    .fsm_state     (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int n_checks  = 0;
  int n_fail    = 0;
  int fe_cnt    = 0;
  int ov_cnt    = 0;
  int start_cyc = 0;
  bit lat_check = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All driving happens on the falling edge, away from the DUT sampling edge.
  task automatic drive_level(input logic v, input int cycles);
    uart_rx = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    start_cyc = cyc + 1;
    drive_level(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_level(b[i], BIT_CLKS);
    drive_level(stop_bit, BIT_CLKS);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_delivery", {24'd0, rx_data}, 32'hFFFF_FFFF);
        end else begin
          check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        end
        if (lat_check) begin
          lat_check = 1'b0;
          check("latency_992pm2", 32'((cyc - start_cyc) >= 990 && (cyc - start_cyc) <= 994), 32'd1);
        end
      end
      if (framing_error) fe_cnt++;
      if (overrun) ov_cnt++;
      if (framing_error && overrun) check("flags_together", 32'd1, 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  int fe0, ov0;

  initial begin
    rst      = 1'b1;
    uart_rx  = 1'b1;
    rx_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_framing_error", {31'd0, framing_error}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    check("reset_state", {29'd0, fsm_state}, 32'd0);
    rst = 1'b0;
    drive_level(1'b1, 20);

    // Single byte with latency measurement.
    exp_q.push_back(8'hA5);
    lat_check = 1'b1;
    send_byte(8'hA5, 1'b1);
    drive_level(1'b1, 20);
    check("single_lat_done", {31'd0, lat_check}, 32'd0);
    check("single_no_fe", 32'(fe_cnt), 32'd0);
    check("single_no_ov", 32'(ov_cnt), 32'd0);

    // Back-to-back frames, no idle gap.
    exp_q.push_back(8'h00);
    send_byte(8'h00, 1'b1);
    exp_q.push_back(8'hFF);
    send_byte(8'hFF, 1'b1);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    drive_level(1'b1, 20);
    check("b2b_drained", 32'(exp_q.size()), 32'd0);
    check("b2b_no_flags", 32'(fe_cnt + ov_cnt), 32'd0);

    // Glitch shorter than half a bit.
    drive_level(1'b0, 20);
    drive_level(1'b1, 200);
    check("glitch_idle", {29'd0, fsm_state}, 32'd0);
    check("glitch_no_flags", 32'(fe_cnt + ov_cnt), 32'd0);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    drive_level(1'b1, 20);
    check("glitch_next_byte", 32'(exp_q.size()), 32'd0);

    // Framing error followed by a held-low break.
    fe0 = fe_cnt;
    send_byte(8'h81, 1'b0);
    drive_level(1'b0, 2 * BIT_CLKS);
    check("break_wait_high", {29'd0, fsm_state}, 32'd4);
    drive_level(1'b1, 2 * BIT_CLKS);
    check("fe_one_pulse", 32'(fe_cnt - fe0), 32'd1);
    check("fe_idle_after", {29'd0, fsm_state}, 32'd0);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    drive_level(1'b1, 20);
    check("fe_next_byte", 32'(exp_q.size()), 32'd0);
    check("fe_no_extra", 32'(fe_cnt - fe0), 32'd1);

    // Overrun under backpressure.
    ov0 = ov_cnt;
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    drive_level(1'b1, 20);
    check("ovr_one_pulse", 32'(ov_cnt - ov0), 32'd1);
    check("ovr_valid_held", {31'd0, rx_valid}, 32'd1);
    check("ovr_data_held", {24'd0, rx_data}, 32'h11);
    rx_ready = 1'b1;
    drive_level(1'b1, 2);
    check("ovr_valid_drop", {31'd0, rx_valid}, 32'd0);
    check("ovr_drained", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(8'h33);
    send_byte(8'h33, 1'b1);
    drive_level(1'b1, 20);
    check("ovr_third_byte", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of data bit 4 of 0xC3; the tester aborts the frame.
    drive_level(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive_level(((8'hC3 >> i) & 8'h01) != 0, BIT_CLKS);
    drive_level(1'b0, BIT_CLKS / 2);
    rst     = 1'b1;
    uart_rx = 1'b1;
    @(negedge clk);
    check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
    check("midrst_flags", {30'd0, framing_error, overrun}, 32'd0);
    check("midrst_state", {29'd0, fsm_state}, 32'd0);
    rst = 1'b0;
    drive_level(1'b1, 3 * BIT_CLKS);
    check("midrst_no_delivery", {31'd0, rx_valid}, 32'd0);
    exp_q.push_back(8'h96);
    send_byte(8'h96, 1'b1);
    drive_level(1'b1, 50);

    // Final report.
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_fe_total", 32'(fe_cnt), 32'd1);
    check("final_ov_total", 32'(ov_cnt), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
